// File: rtl/marc_sequencer.sv
// mARC control-unit next-state engine: one-hot state register, memory wait
// timeout, trap/interrupt entry and sticky bus_err/illegal flags.
module marc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic [4:0]  status,
    input  logic        mem_ready,
    input  logic        irq,
    output logic [12:0] state,
    output logic        ir_we,
    output logic        mem_req,
    output logic        irq_ack,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal
);

    localparam logic [12:0] S_HALT   = 13'h0000;
    localparam logic [12:0] S_FETCH  = 13'h0001;
    localparam logic [12:0] S_DECODE = 13'h0002;
    localparam logic [12:0] S_IMM    = 13'h0004;
    localparam logic [12:0] S_ALU    = 13'h0008;
    localparam logic [12:0] S_SHIFT  = 13'h0010;
    localparam logic [12:0] S_MEM    = 13'h0020;
    localparam logic [12:0] S_BRADDR = 13'h0040;
    localparam logic [12:0] S_BREVAL = 13'h0080;
    localparam logic [12:0] S_SETHI  = 13'h0100;
    localparam logic [12:0] S_MADDR  = 13'h0200;
    localparam logic [12:0] S_CALL   = 13'h0400;
    localparam logic [12:0] S_PCINC  = 13'h0800;
    localparam logic [12:0] S_TRAP   = 13'h1000;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [12:0]      state_nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic             trap_irq;
    logic             irq_entry;
    logic             set_bus_err;
    logic             set_illegal;
    logic             tmo_hit;
    logic             cnt_clear;
    logic             irq_take;
    logic             unused_bits;

    // Condition codes: Z=status[0], N=status[1], V=status[2].
    function automatic logic br_taken(input logic [2:0] cond, input logic [4:0] psr);
        logic lt;
        lt = psr[1] ^ psr[2];
        case (cond)
            3'b000, 3'b001: br_taken = 1'b1;
            3'b010:         br_taken = ~psr[0];
            3'b011:         br_taken = psr[0];
            3'b100:         br_taken = ~(psr[0] | lt);
            3'b101:         br_taken = psr[0] | lt;
            3'b110:         br_taken = ~lt;
            default:        br_taken = lt;
        endcase
    endfunction

    assign unused_bits = ^{status[3], ir[11], ir[7:5], ir[3:0]};
    assign irq_take    = irq & status[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else if (run) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        irq_entry   = 1'b0;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        tmo_hit     = ~mem_ready && (wait_cnt == TMO_LAST);
        case (state)
            S_HALT: begin
                if (irq_take) begin
                    state_nxt = S_TRAP;
                    irq_entry = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (tmo_hit) begin
                    state_nxt   = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (!ir[15]) begin
                    if (ir[14:12] == 3'b111) state_nxt = S_SHIFT;
                    else if (ir[4])          state_nxt = S_IMM;
                    else                     state_nxt = S_ALU;
                end else begin
                    case (ir[14:12])
                        3'b000:  state_nxt = S_MADDR;
                        3'b001:  state_nxt = S_BRADDR;
                        3'b010:  state_nxt = S_SETHI;
                        3'b011:  state_nxt = S_CALL;
                        3'b111:  state_nxt = S_HALT;
                        default: begin
                            state_nxt   = S_TRAP;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
            end
            S_IMM:                    state_nxt = S_ALU;
            S_ALU, S_SHIFT, S_SETHI:  state_nxt = S_PCINC;
            S_MADDR:                  state_nxt = S_MEM;
            S_MEM: begin
                if (mem_ready) begin
                    state_nxt = S_PCINC;
                end else if (tmo_hit) begin
                    state_nxt   = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_BRADDR:                 state_nxt = S_BREVAL;
            S_BREVAL:                 state_nxt = br_taken(ir[10:8], status) ? S_FETCH : S_PCINC;
            S_CALL:                   state_nxt = S_FETCH;
            S_PCINC: begin
                if (irq_take) begin
                    state_nxt = S_TRAP;
                    irq_entry = 1'b1;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_TRAP:                   state_nxt = S_FETCH;
            // Not one-hot and not halt: recover through the trap state.
            default:                  state_nxt = S_TRAP;
        endcase
    end

    // Wait counter restarts whenever a memory-wait state is freshly entered.
    assign cnt_clear = ((state_nxt == S_FETCH) || (state_nxt == S_MEM)) && (state_nxt != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            illegal  <= 1'b0;
            trap_irq <= 1'b0;
        end else if (run) begin
            trap_irq <= irq_entry;
            if (set_bus_err) bus_err <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
            if (cnt_clear) begin
                wait_cnt <= '0;
            end else if ((state[0] | state[5]) && !mem_ready) begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end
        end
    end

    always_comb begin
        ir_we   = state[0] & mem_ready & run;
        mem_req = state[0] | state[5];
        halted  = (state == S_HALT);
        irq_ack = state[12] & trap_irq;
    end

endmodule
